// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: EX/MEM to MEM/WB with a req/ack data-memory port.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (drop misaligned accesses and pulse misalign_err).
module mem_stage_lsu #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]      EX_MEM_dataB,
    input  logic [6:0]                EX_MEM_inst_opcode,
    input  logic [2:0]                EX_MEM_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic                      EX_MEM_reg_write_en,
    input  logic                      EX_MEM_mem_write_en,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [REG_WIDTH-1:0]      dmem_addr,
    output logic [REG_WIDTH-1:0]      dmem_wdata,
    output logic [3:0]                dmem_wstrb,
    input  logic [REG_WIDTH-1:0]      dmem_rdata,
    input  logic                      dmem_ack,
    output logic                      stall,
    output logic [REG_WIDTH-1:0]      MEM_WB_result,
    output logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
    output logic                      MEM_WB_reg_write_en,
    output logic                      misalign_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t state, state_next;

    logic                 is_load;
    logic                 is_store;
    logic                 is_memop;
    logic                 trap;
    logic                 issue;
    logic [1:0]           size;
    logic [1:0]           off;
    logic [REG_WIDTH-1:0] st_wdata;
    logic [3:0]           st_wstrb;

    logic [1:0]           ld_off;
    logic [2:0]           ld_funct3;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [REG_WIDTH-1:0] load_data;

    assign is_load  = (EX_MEM_inst_opcode == OP_LOAD);
    assign is_store = (EX_MEM_inst_opcode == OP_STORE) && EX_MEM_mem_write_en;
    assign is_memop = is_load || is_store;
    // funct3[1:0]: 00 byte, 01 half, 10/11 word (unknown encodings fall back to word)
    assign size     = EX_MEM_funct3[1:0];
    assign off      = EX_MEM_alu_out[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned = ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
    assign trap       = is_memop && misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (state == IDLE) && trap;
        end
    end
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and stall
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_memop && !trap) begin
                    stall      = 1'b1;
                    issue      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = ~dmem_ack;
                if (dmem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Store lane replication; half strobes use addr[1] only so a truncated
    // misaligned half still lands on a legal lane pair.
    always_comb begin
        st_wdata = EX_MEM_dataB;
        st_wstrb = 4'b1111;
        unique case (size)
            2'b00: begin
                st_wdata = {(REG_WIDTH/8){EX_MEM_dataB[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {(REG_WIDTH/16){EX_MEM_dataB[15:0]}};
                st_wstrb = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                st_wdata = EX_MEM_dataB;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load extraction from the offset and size captured at issue
    always_comb begin
        ld_byte   = dmem_rdata[{ld_off, 3'b000} +: 8];
        ld_half   = dmem_rdata[{ld_off[1], 4'b0000} +: 16];
        load_data = dmem_rdata;
        unique case (ld_funct3)
            3'b000:  load_data = {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(REG_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(REG_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(REG_WIDTH-16){1'b0}}, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Memory port and MEM/WB registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req            <= 1'b0;
            dmem_we             <= 1'b0;
            dmem_addr           <= '0;
            dmem_wdata          <= '0;
            dmem_wstrb          <= '0;
            MEM_WB_result       <= '0;
            MEM_WB_rd           <= '0;
            MEM_WB_reg_write_en <= 1'b0;
            ld_off              <= '0;
            ld_funct3           <= '0;
        end else if (state == IDLE) begin
            if (issue) begin
                MEM_WB_reg_write_en <= 1'b0;
                dmem_req            <= 1'b1;
                dmem_we             <= is_store;
                dmem_addr           <= {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
                dmem_wdata          <= is_store ? st_wdata : '0;
                dmem_wstrb          <= is_store ? st_wstrb : '0;
                ld_off              <= off;
                ld_funct3           <= EX_MEM_funct3;
            end else if (trap) begin
                MEM_WB_reg_write_en <= 1'b0;
            end else begin
                MEM_WB_result       <= EX_MEM_alu_out;
                MEM_WB_rd           <= EX_MEM_rd;
                MEM_WB_reg_write_en <= EX_MEM_reg_write_en;
            end
        end else begin
            if (dmem_ack) begin
                dmem_req <= 1'b0;
                if (!dmem_we) begin
                    MEM_WB_result       <= load_data;
                    MEM_WB_rd           <= EX_MEM_rd;
                    MEM_WB_reg_write_en <= EX_MEM_reg_write_en;
                end else begin
                    MEM_WB_reg_write_en <= 1'b0;
                end
            end else begin
                MEM_WB_reg_write_en <= 1'b0;
            end
        end
    end

endmodule
